csr_trap_unit: RTL and testbench
================================

# csr_trap_unit

Parametrised machine-mode CSR file and trap controller for the core. It extends the base CSR set with `NUM_IRQ` edge-latched external interrupts and `mstatus` MIE/MPIE nesting control. It also adds fixed-priority cause encoding, vectored/direct `mtvec`, MRET handling and an optional `mtimecmp` timer interrupt. It sits beside the execute stage: the core presents CSR instructions and retirement boundaries, and the block returns read data plus a trap-redirect request.

## Interface
- `NUM_IRQ`, default 6: number of external interrupt lines, legal range 1..16.
- `i_CLK` in 1: clock.
- `i_RSTn` in 1: synchronous, active-low reset.
- `i_CSR_EN` in 1: a CSR instruction is executing this cycle.
- `i_CSR_FUNCT3` in 3: 001/101 write, 010/110 set, 011/111 clear; other values mean no write.
- `i_CSR_ADDR` in 12: CSR address.
- `i_CSR_WDATA` in 32: operand; the core resolves rs1 versus immediate before this input.
- `i_RETIRE` in 1: instruction boundary; the only cycle in which a trap may be taken.
- `i_MRET` in 1: MRET executing, qualified by `i_RETIRE`.
- `i_PC` in 32: PC of the instruction at the boundary.
- `i_INSTR` in 32: instruction word at the boundary.
- `i_IRQ` in NUM_IRQ: external interrupt lines, synchronous to `i_CLK`.
- `o_CSR_RDATA` out 32: old value of the addressed CSR, combinational.
- `o_TRAP` out 1: take-trap request, combinational.
- `o_TRAP_PC` out 32: handler target, valid while `o_TRAP`=1.
- `o_MEPC` out 32: current `mepc`, used as the MRET target.
- `o_IN_TRAP` out 1: handler is executing, registered.

## Operation
- **Address map:**
  - 0x300 `mstatus`: bit3 MIE, bit7 MPIE; all other bits read 0.
  - 0x304 `mie`.
  - 0x305 `mtvec`: bit1 forced 0.
  - 0x340 `mscratch`.
  - 0x341 `mepc`: bits[1:0] forced 0.
  - 0x342 `mcause`, 0x343 `mtval`.
  - 0x344 `mip`: only the clear operation has effect.
  - 0xB00 `mcycle`, 0xB80 `mcycleh`: read-only 64-bit cycle counter.
  - Unmapped addresses read 0 and ignore writes.
- **Pending latch:** `mip[16+i]` is set on a rising edge of `i_IRQ[i]` (current 1, previous 0). It is cleared only by a CSR clear to `mip`. If a set and a clear hit the same bit in the same cycle, the set wins.
- **Enable mask:** only `mie` bits [16+NUM_IRQ-1:16] and bit 7 are writable.
- **Trap condition:** `o_TRAP` = `i_RETIRE` & ~`i_MRET` & MIE & |(`mip` & `mie`).
- **Priority:** the timer (bit 7) first, then external interrupts with the lowest index highest.
- **Cause code:** timer = 7; external interrupt i = 16+i. `mcause` = {1'b1, 26'b0, code[4:0]}.
- **`o_TRAP_PC`:**
  - `mtvec[0]`=0: {`mtvec[31:2]`, 2'b00}.
  - `mtvec[0]`=1: {`mtvec[31:2]`, 2'b00} + 4·code.
- **Trap entry, at the clock edge:**
  - `mepc` ← `i_PC`, `mtval` ← `i_INSTR`, `mcause` ← cause.
  - MPIE ← MIE, MIE ← 0.
  - State goes RUN → HANDLER.
- **MRET (`i_RETIRE` & `i_MRET`):** MIE ← MPIE, MPIE ← 1, state goes HANDLER → RUN. An MRET while already in RUN still updates MIE/MPIE.
- **State machine:** two states, RUN and HANDLER. `o_IN_TRAP` = (state==HANDLER). No nesting occurs, because MIE=0 while in the handler unless software sets it. A trap taken while in HANDLER re-enters HANDLER.
- **Simultaneous CSR write and trap:** trap-entry updates win for `mstatus`, `mepc`, `mcause` and `mtval`. Writes to any other CSR complete normally.

## Timing
- **Reset values:**
  - All CSRs 0; `mtimecmp` all-ones.
  - State RUN, `o_TRAP`=0, `o_IN_TRAP`=0, `o_MEPC`=0.
  - The `i_IRQ` history register is cleared to 0, so a line held high through reset latches once after reset.
- CSR reads are combinational and return the pre-write value. Writes become visible the following cycle.
- An `i_IRQ` edge sampled at edge N sets `mip` at N. The earliest trap is in the cycle after edge N, provided `i_RETIRE` is high.
- `mcycle` increments every cycle after reset and wraps from 2^64−1 to 0.
- Reset asserted mid-handler returns the block to RUN immediately, with all pending bits cleared.

## Configuration
- **`CSR_TIMER_EN` defined:**
  - Adds `mtimecmp` at 0x7C0 (low word) and 0x7C1 (high word), both read/write.
  - `mip[7]` = ({`mcycleh`, `mcycle`} >= `mtimecmp`), level-sensitive; clearing it in `mip` has no effect.
  - The timer can raise cause 7.
- **`CSR_TIMER_EN` undefined:**
  - 0x7C0 and 0x7C1 are unmapped.
  - `mip[7]` and `mie[7]` read 0 and are unwritable.

## Test plan
- **Direct mode entry:** `mtvec`=0x100, `mie[16]`=1, MIE=1. Pulse `i_IRQ[0]`, then retire at PC 0x40.
  - Expect `o_TRAP`=1, `o_TRAP_PC`=0x100, `mepc`=0x40, `mcause`=0x80000010, MIE=0, MPIE=1, `o_IN_TRAP`=1.
- **Vectored priority:** `mtvec`=0x201 (base 0x200, vectored). Raise `i_IRQ[3]` and `i_IRQ[1]` in the same cycle.
  - Expect cause 17 and `o_TRAP_PC`=0x244.
- **Masking and MRET:** MIE=0 with `mip[16]` pending.
  - Expect no trap across 10 retires.
  - Then enter the handler and execute MRET. Expect MIE=1, `o_IN_TRAP`=0, and a re-trap on the next retire because the bit is still pending.
- **Set/clear collision:** CSR clear of `mip` bit16 in the same cycle as a new `i_IRQ[0]` edge.
  - Expect `mip[16]`=1.
- **CSR ops:** write `mscratch`=0xF0F0, set 0x000F, clear 0x00F0.
  - Reads return 0xF0F0, then 0xF0FF, then 0xF00F. Writes to `mcycle` are ignored.
- **Timer (`CSR_TIMER_EN`):** `mtimecmp`=50, `mie[7]`=1, MIE=1.
  - Expect the trap at the first retire with `mcycle` ≥ 50, with `mcause`=0x80000007.

Source files
------------

// File: rtl/csr_trap_unit_if.sv
// -----------------------------------------------------------------------------
// csr_trap_unit_if
// Bundles the execute-stage side of the machine-mode CSR file / trap unit.
//
// Strobe semantics: i_CSR_EN and i_RETIRE are single-cycle qualifiers. The
// unit samples them on every i_CLK edge and never applies back-pressure. A
// CSR access or a boundary is accepted in the cycle its strobe is high.
// All o_* outputs except o_IN_TRAP and o_DBG_STATE are combinational from
// the current inputs and the registered CSR state.
//
// Signals (core -> unit):
//   i_CSR_EN, i_CSR_FUNCT3, i_CSR_ADDR, i_CSR_WDATA : CSR instruction
//   i_RETIRE, i_MRET, i_PC, i_INSTR                 : instruction boundary
//   i_IRQ[NUM_IRQ-1:0]                              : external interrupts
// Signals (unit -> core):
//   o_CSR_RDATA : old value of the addressed CSR
//   o_TRAP      : take-trap request
//   o_TRAP_PC   : handler target while o_TRAP=1
//   o_MEPC      : current mepc (MRET target)
//   o_IN_TRAP   : handler executing
//   o_DBG_STATE : raw trap FSM state (0 = RUN, 1 = HANDLER)
// Modports: master = core side, slave = csr_trap_unit.
// -----------------------------------------------------------------------------
interface csr_trap_unit_if #(
    parameter int NUM_IRQ = 6
);
    logic               i_CSR_EN;
    logic [2:0]         i_CSR_FUNCT3;
    logic [11:0]        i_CSR_ADDR;
    logic [31:0]        i_CSR_WDATA;
    logic               i_RETIRE;
    logic               i_MRET;
    logic [31:0]        i_PC;
    logic [31:0]        i_INSTR;
    logic [NUM_IRQ-1:0] i_IRQ;
    logic [31:0]        o_CSR_RDATA;
    logic               o_TRAP;
    logic [31:0]        o_TRAP_PC;
    logic [31:0]        o_MEPC;
    logic               o_IN_TRAP;
    logic               o_DBG_STATE;

    modport master (
        output i_CSR_EN, i_CSR_FUNCT3, i_CSR_ADDR, i_CSR_WDATA,
        output i_RETIRE, i_MRET, i_PC, i_INSTR, i_IRQ,
        input  o_CSR_RDATA, o_TRAP, o_TRAP_PC, o_MEPC, o_IN_TRAP, o_DBG_STATE
    );

    modport slave (
        input  i_CSR_EN, i_CSR_FUNCT3, i_CSR_ADDR, i_CSR_WDATA,
        input  i_RETIRE, i_MRET, i_PC, i_INSTR, i_IRQ,
        output o_CSR_RDATA, o_TRAP, o_TRAP_PC, o_MEPC, o_IN_TRAP, o_DBG_STATE
    );
endinterface

// File: rtl/csr_trap_unit.sv
// -----------------------------------------------------------------------------
// csr_trap_unit
// Machine-mode CSR file and trap controller. Holds mstatus (MIE/MPIE), mie,
// mtvec, mscratch, mepc, mcause, mtval, an edge-latched mip and a 64-bit
// mcycle counter. It decides at each retirement boundary whether to redirect
// to the trap handler and tracks RUN/HANDLER state, including MRET.
//
// Ports:
//   i_CLK   : clock
//   i_RSTn  : synchronous, active-low reset
//   bus     : csr_trap_unit_if.slave (CSR access, boundary, IRQs, results)
//
// Build option:
//   CSR_TIMER_EN : adds mtimecmp (0x7C0/0x7C1), the level-sensitive timer
//                  pending bit mip[7], writable mie[7] and cause 7.
// -----------------------------------------------------------------------------
module csr_trap_unit #(
    parameter int NUM_IRQ = 6
) (
    input  logic           i_CLK,
    input  logic           i_RSTn,
    csr_trap_unit_if.slave bus
);
    typedef enum logic {ST_RUN = 1'b0, ST_HANDLER = 1'b1} state_t;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;

    // Writable mie bits: one per external line starting at bit 16.
    localparam logic [31:0] EXT_MASK = ((32'd1 << NUM_IRQ) - 32'd1) << 16;
`ifdef CSR_TIMER_EN
    localparam logic [11:0] A_MTIMECMP  = 12'h7C0;
    localparam logic [11:0] A_MTIMECMPH = 12'h7C1;
    localparam logic [31:0] MIE_MASK    = EXT_MASK | 32'h0000_0080;
`else
    localparam logic [31:0] MIE_MASK    = EXT_MASK;
`endif

    state_t             state_q, state_d;
    logic               mie_bit_q, mie_bit_d;   // mstatus.MIE
    logic               mpie_q, mpie_d;         // mstatus.MPIE
    logic [31:0]        mie_q, mie_d;
    logic [31:0]        mtvec_q, mtvec_d;
    logic [31:0]        mscratch_q, mscratch_d;
    logic [31:0]        mepc_q, mepc_d;
    logic [31:0]        mcause_q, mcause_d;
    logic [31:0]        mtval_q, mtval_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;         // mip[16 +: NUM_IRQ]
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [63:0]        mcycle_q, mcycle_d;
`ifdef CSR_TIMER_EN
    logic [63:0]        mtimecmp_q, mtimecmp_d;
`endif

    logic [31:0]        mip_val;
    logic [31:0]        rdata;
    logic [31:0]        pending;
    logic [4:0]         code;
    logic               trap;
    logic [31:0]        trap_pc;
    logic               csr_we;
    logic [31:0]        csr_new;
    logic [NUM_IRQ-1:0] pend_clr;

    // Visible mip: latched external bits plus the live timer comparison.
    always_comb begin
        mip_val = 32'd0;
        mip_val[16 +: NUM_IRQ] = pend_q;
`ifdef CSR_TIMER_EN
        mip_val[7] = (mcycle_q >= mtimecmp_q);
`endif
    end

    always_comb begin
        rdata = 32'd0;
        case (bus.i_CSR_ADDR)
            A_MSTATUS:   rdata = {24'd0, mpie_q, 3'd0, mie_bit_q, 3'd0};
            A_MIE:       rdata = mie_q;
            A_MTVEC:     rdata = mtvec_q;
            A_MSCRATCH:  rdata = mscratch_q;
            A_MEPC:      rdata = mepc_q;
            A_MCAUSE:    rdata = mcause_q;
            A_MTVAL:     rdata = mtval_q;
            A_MIP:       rdata = mip_val;
            A_MCYCLE:    rdata = mcycle_q[31:0];
            A_MCYCLEH:   rdata = mcycle_q[63:32];
`ifdef CSR_TIMER_EN
            A_MTIMECMP:  rdata = mtimecmp_q[31:0];
            A_MTIMECMPH: rdata = mtimecmp_q[63:32];
`endif
            default:     rdata = 32'd0;
        endcase
    end

    // Fixed priority: timer first, then the lowest-numbered external line.
    // The loop runs high-to-low so the lowest index overwrites last.
    always_comb begin
        pending = mip_val & mie_q;
        code    = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[16 + i]) code = 5'(16 + i);
        end
        if (pending[7]) code = 5'd7;
        trap    = bus.i_RETIRE & ~bus.i_MRET & mie_bit_q & (|pending);
        trap_pc = {mtvec_q[31:2], 2'b00} + (mtvec_q[0] ? {25'd0, code, 2'b00} : 32'd0);
    end

    // funct3[1:0]: 01 write, 10 set, 11 clear, 00 no write.
    always_comb begin
        csr_we = bus.i_CSR_EN & (bus.i_CSR_FUNCT3[1:0] != 2'b00);
        case (bus.i_CSR_FUNCT3[1:0])
            2'b01:   csr_new = bus.i_CSR_WDATA;
            2'b10:   csr_new = rdata | bus.i_CSR_WDATA;
            default: csr_new = rdata & ~bus.i_CSR_WDATA;
        endcase
    end

    // Next-state: CSR writes first, then trap entry / MRET override the
    // mstatus/mepc/mcause/mtval fields they own.
    always_comb begin
        state_d    = state_q;
        mie_bit_d  = mie_bit_q;
        mpie_d     = mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        pend_clr   = '0;
        mcycle_d   = mcycle_q + 64'd1;
`ifdef CSR_TIMER_EN
        mtimecmp_d = mtimecmp_q;
`endif
        if (csr_we) begin
            case (bus.i_CSR_ADDR)
                A_MSTATUS: begin
                    mie_bit_d = csr_new[3];
                    mpie_d    = csr_new[7];
                end
                A_MIE:       mie_d      = csr_new & MIE_MASK;
                A_MTVEC:     mtvec_d    = csr_new & 32'hFFFF_FFFD;
                A_MSCRATCH:  mscratch_d = csr_new;
                A_MEPC:      mepc_d     = csr_new & 32'hFFFF_FFFC;
                A_MCAUSE:    mcause_d   = csr_new;
                A_MTVAL:     mtval_d    = csr_new;
                // Only a clear reaches mip; write/set are ignored.
                A_MIP: if (bus.i_CSR_FUNCT3[1:0] == 2'b11) pend_clr = bus.i_CSR_WDATA[16 +: NUM_IRQ];
`ifdef CSR_TIMER_EN
                A_MTIMECMP:  mtimecmp_d[31:0]  = csr_new;
                A_MTIMECMPH: mtimecmp_d[63:32] = csr_new;
`endif
                default: ;
            endcase
        end

        // Set after clear: a fresh edge in the same cycle survives the clear.
        pend_d     = (pend_q & ~pend_clr) | (bus.i_IRQ & ~irq_prev_q);
        irq_prev_d = bus.i_IRQ;

        if (trap) begin
            mepc_d    = bus.i_PC & 32'hFFFF_FFFC;
            mtval_d   = bus.i_INSTR;
            mcause_d  = {1'b1, 26'd0, code};
            mpie_d    = mie_bit_q;
            mie_bit_d = 1'b0;
            state_d   = ST_HANDLER;
        end else if (bus.i_RETIRE && bus.i_MRET) begin
            mie_bit_d = mpie_q;
            mpie_d    = 1'b1;
            state_d   = ST_RUN;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            state_q    <= ST_RUN;
            mie_bit_q  <= 1'b0;
            mpie_q     <= 1'b0;
            mie_q      <= 32'd0;
            mtvec_q    <= 32'd0;
            mscratch_q <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mtval_q    <= 32'd0;
            pend_q     <= '0;
            irq_prev_q <= '0;
            mcycle_q   <= 64'd0;
`ifdef CSR_TIMER_EN
            mtimecmp_q <= '1;
`endif
        end else begin
            state_q    <= state_d;
            mie_bit_q  <= mie_bit_d;
            mpie_q     <= mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            pend_q     <= pend_d;
            irq_prev_q <= irq_prev_d;
            mcycle_q   <= mcycle_d;
`ifdef CSR_TIMER_EN
            mtimecmp_q <= mtimecmp_d;
`endif
        end
    end

    assign bus.o_CSR_RDATA = rdata;
    assign bus.o_TRAP      = trap;
    assign bus.o_TRAP_PC   = trap_pc;
    assign bus.o_MEPC      = mepc_q;
    assign bus.o_IN_TRAP   = (state_q == ST_HANDLER);
    assign bus.o_DBG_STATE = state_q;
endmodule

// File: tb/tb_csr_trap_unit.sv
// -----------------------------------------------------------------------------
// tb_csr_trap_unit
// Bench for csr_trap_unit (NUM_IRQ = 6). A directed vector table and short
// hand-written sequences run first. These are followed by randomized
// traffic. A behavioural model of the CSR/trap rules is checked every cycle.
// With CSR_TIMER_EN defined, a timer trap sequence is added.
// -----------------------------------------------------------------------------
module tb_csr_trap_unit;
    localparam int N = 6;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    csr_trap_unit_if #(.NUM_IRQ(N)) bus ();
    csr_trap_unit #(.NUM_IRQ(N)) dut (.i_CLK(clk), .i_RSTn(rstn), .bus(bus));

    int total = 0;
    int bad   = 0;

    // ---------------- reference model state ----------------
    bit          m_mie_bit, m_mpie, m_handler;
    logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    bit          m_pend[N];
    bit          m_prev[N];
    logic [63:0] m_cycle, m_tcmp;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mie_mask();
        logic [31:0] m = 32'd0;
        for (int i = 0; i < N; i++) m[16 + i] = 1'b1;
`ifdef CSR_TIMER_EN
        m[7] = 1'b1;
`endif
        return m;
    endfunction

    function automatic logic [31:0] m_mip();
        logic [31:0] v = 32'd0;
        for (int i = 0; i < N; i++) if (m_pend[i]) v = v + (32'd1 << (16 + i));
`ifdef CSR_TIMER_EN
        if (m_cycle >= m_tcmp) v = v + 32'h80;
`endif
        return v;
    endfunction

    function automatic logic [31:0] m_read(logic [11:0] a);
        case (a)
            12'h300: return (m_mpie ? 32'h80 : 32'h0) + (m_mie_bit ? 32'h8 : 32'h0);
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return m_mip();
            12'hB00: return m_cycle[31:0];
            12'hB80: return m_cycle[63:32];
`ifdef CSR_TIMER_EN
            12'h7C0: return m_tcmp[31:0];
            12'h7C1: return m_tcmp[63:32];
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Cause code of the highest-priority enabled pending source, -1 if none.
    function automatic int m_code();
        logic [31:0] p = m_mip() & m_mie;
        if (p[7]) return 7;
        for (int i = 0; i < N; i++) if (p[16 + i]) return 16 + i;
        return -1;
    endfunction

    task automatic model_reset();
        m_mie_bit = 0; m_mpie = 0; m_handler = 0;
        m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_prev[i] = 0; end
        m_cycle = 0;
        m_tcmp  = '1;
    endtask

    task automatic model_check();
        int  c  = m_code();
        bit  et = bus.i_RETIRE && !bus.i_MRET && m_mie_bit && (c >= 0);
        chk("m_rdata", bus.o_CSR_RDATA, m_read(bus.i_CSR_ADDR));
        chk("m_trap", {31'd0, bus.o_TRAP}, {31'd0, et});
        if (et) chk("m_trap_pc", bus.o_TRAP_PC,
                    (m_mtvec & 32'hFFFF_FFFC) + (m_mtvec[0] ? 32'(4 * c) : 32'd0));
        chk("m_mepc", bus.o_MEPC, m_mepc);
        chk("m_in_trap", {31'd0, bus.o_IN_TRAP}, {31'd0, m_handler});
    endtask

    task automatic model_step();
        int          c     = m_code();
        bit          take  = bus.i_RETIRE && !bus.i_MRET && m_mie_bit && (c >= 0);
        bit          o_mie = m_mie_bit;
        bit          o_mpie = m_mpie;
        logic [31:0] wd    = bus.i_CSR_WDATA;
        logic [31:0] old, nw;
        logic [1:0]  op    = bus.i_CSR_FUNCT3[1:0];
        if (bus.i_CSR_EN && op != 2'b00) begin
            old = m_read(bus.i_CSR_ADDR);
            nw  = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
            case (bus.i_CSR_ADDR)
                12'h300: begin m_mie_bit = nw[3]; m_mpie = nw[7]; end
                12'h304: m_mie = nw & mie_mask();
                12'h305: m_mtvec = nw & 32'hFFFF_FFFD;
                12'h340: m_mscratch = nw;
                12'h341: m_mepc = nw & 32'hFFFF_FFFC;
                12'h342: m_mcause = nw;
                12'h343: m_mtval = nw;
                12'h344: if (op == 2'b11) for (int i = 0; i < N; i++) if (wd[16 + i]) m_pend[i] = 0;
`ifdef CSR_TIMER_EN
                12'h7C0: m_tcmp[31:0] = nw;
                12'h7C1: m_tcmp[63:32] = nw;
`endif
                default: ;
            endcase
        end
        for (int i = 0; i < N; i++) begin
            if (bus.i_IRQ[i] && !m_prev[i]) m_pend[i] = 1;
            m_prev[i] = bus.i_IRQ[i];
        end
        if (take) begin
            m_mepc    = bus.i_PC & 32'hFFFF_FFFC;
            m_mtval   = bus.i_INSTR;
            m_mcause  = 32'h8000_0000 | 32'(c);
            m_mpie    = o_mie;
            m_mie_bit = 0;
            m_handler = 1;
        end else if (bus.i_RETIRE && bus.i_MRET) begin
            m_mie_bit = o_mpie;
            m_mpie    = 1;
            m_handler = 0;
        end
        m_cycle = m_cycle + 64'd1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(logic en, logic [2:0] f3, logic [11:0] a, logic [31:0] wd,
                          logic ret, logic mret, logic [31:0] pc, logic [N-1:0] irq);
        bus.i_CSR_EN     = en;
        bus.i_CSR_FUNCT3 = f3;
        bus.i_CSR_ADDR   = a;
        bus.i_CSR_WDATA  = wd;
        bus.i_RETIRE     = ret;
        bus.i_MRET       = mret;
        bus.i_PC         = pc;
        bus.i_INSTR      = ~pc;
        bus.i_IRQ        = irq;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        if (!rstn) model_reset();
        else begin model_check(); model_step(); end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        settle();
        finish_cycle();
    endtask

    task automatic do_reset(logic [N-1:0] irq_hold);
        rstn = 1'b0;
        set_in(0, 3'd0, 12'h000, 32'd0, 0, 0, 32'd0, irq_hold);
        repeat (2) tick();
        rstn = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        en;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] wd;
        logic        ret;
        logic        mret;
        logic [31:0] pc;
        logic [N-1:0] irq;
        logic [31:0] exp_rd;
        logic        exp_trap;
        logic [31:0] exp_tpc;
        logic        exp_it;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    function automatic vec_t mkv(logic en, logic [2:0] f3, logic [11:0] a, logic [31:0] wd,
                                 logic ret, logic mret, logic [31:0] pc, logic [N-1:0] irq,
                                 logic [31:0] rd, logic tr, logic [31:0] tpc, logic it);
        vec_t v;
        v.en = en; v.f3 = f3; v.addr = a; v.wd = wd; v.ret = ret; v.mret = mret;
        v.pc = pc; v.irq = irq; v.exp_rd = rd; v.exp_trap = tr; v.exp_tpc = tpc; v.exp_it = it;
        return v;
    endfunction

    logic [N-1:0] irq_r;
    bit           found;

    initial begin
        rstn = 1'b0;
        set_in(0, 3'd0, 12'h000, 32'd0, 0, 0, 32'd0, '0);

        // CSR ops on mscratch, direct-mode entry, vectored priority.
        vecs[0]  = mkv(1, 3'd1, 12'h340, 32'h0000_F0F0, 0, 0, 32'h0,  6'b000000, 32'h0000_0000, 0, 32'h0,   0);
        vecs[1]  = mkv(1, 3'd2, 12'h340, 32'h0000_000F, 0, 0, 32'h0,  6'b000000, 32'h0000_F0F0, 0, 32'h0,   0);
        vecs[2]  = mkv(1, 3'd3, 12'h340, 32'h0000_00F0, 0, 0, 32'h0,  6'b000000, 32'h0000_F0FF, 0, 32'h0,   0);
        vecs[3]  = mkv(1, 3'd0, 12'h340, 32'h0000_0000, 0, 0, 32'h0,  6'b000000, 32'h0000_F00F, 0, 32'h0,   0);
        vecs[4]  = mkv(1, 3'd1, 12'h305, 32'h0000_0100, 0, 0, 32'h0,  6'b000000, 32'h0000_0000, 0, 32'h0,   0);
        vecs[5]  = mkv(1, 3'd1, 12'h304, 32'h0001_0000, 0, 0, 32'h0,  6'b000000, 32'h0000_0000, 0, 32'h0,   0);
        vecs[6]  = mkv(1, 3'd1, 12'h300, 32'h0000_0008, 0, 0, 32'h0,  6'b000000, 32'h0000_0000, 0, 32'h0,   0);
        vecs[7]  = mkv(0, 3'd0, 12'h300, 32'h0,         0, 0, 32'h0,  6'b000001, 32'h0000_0008, 0, 32'h0,   0);
        vecs[8]  = mkv(0, 3'd0, 12'h344, 32'h0,         1, 0, 32'h40, 6'b000001, 32'h0001_0000, 1, 32'h100, 0);
        vecs[9]  = mkv(0, 3'd0, 12'h341, 32'h0,         0, 0, 32'h0,  6'b000000, 32'h0000_0040, 0, 32'h0,   1);
        vecs[10] = mkv(0, 3'd0, 12'h342, 32'h0,         0, 0, 32'h0,  6'b000000, 32'h8000_0010, 0, 32'h0,   1);
        vecs[11] = mkv(0, 3'd0, 12'h300, 32'h0,         0, 0, 32'h0,  6'b000000, 32'h0000_0080, 0, 32'h0,   1);
        vecs[12] = mkv(0, 3'd0, 12'h343, 32'h0,         0, 0, 32'h0,  6'b000000, 32'hFFFF_FFBF, 0, 32'h0,   1);
        vecs[13] = mkv(0, 3'd0, 12'h344, 32'h0,         0, 0, 32'h0,  6'b000000, 32'h0001_0000, 0, 32'h0,   1);
        vecs[14] = mkv(1, 3'd1, 12'h305, 32'h0000_0201, 0, 0, 32'h0,  6'b000000, 32'h0000_0100, 0, 32'h0,   1);
        vecs[15] = mkv(1, 3'd3, 12'h344, 32'h0001_0000, 0, 0, 32'h0,  6'b000000, 32'h0001_0000, 0, 32'h0,   1);
        vecs[16] = mkv(1, 3'd0, 12'h344, 32'h0,         0, 0, 32'h0,  6'b000000, 32'h0000_0000, 0, 32'h0,   1);
        vecs[17] = mkv(1, 3'd1, 12'h304, 32'h000F_0000, 0, 0, 32'h0,  6'b000000, 32'h0001_0000, 0, 32'h0,   1);
        vecs[18] = mkv(0, 3'd0, 12'h305, 32'h0,         1, 1, 32'h44, 6'b000000, 32'h0000_0201, 0, 32'h0,   1);
        vecs[19] = mkv(0, 3'd0, 12'h300, 32'h0,         0, 0, 32'h0,  6'b001010, 32'h0000_0088, 0, 32'h0,   0);
        vecs[20] = mkv(0, 3'd0, 12'h344, 32'h0,         1, 0, 32'h80, 6'b001010, 32'h000A_0000, 1, 32'h244, 0);
        vecs[21] = mkv(0, 3'd0, 12'h342, 32'h0,         0, 0, 32'h0,  6'b000000, 32'h8000_0011, 0, 32'h0,   1);
        vecs[22] = mkv(0, 3'd0, 12'h341, 32'h0,         0, 0, 32'h0,  6'b000000, 32'h0000_0080, 0, 32'h0,   1);

        do_reset('0);

        // Reset state, probed with a retire so o_TRAP must stay low.
        set_in(0, 3'd0, 12'hB00, 32'd0, 1, 0, 32'h10, '0);
        settle();
        chk("rst_mcycle", bus.o_CSR_RDATA, 32'd0);
        chk("rst_trap", {31'd0, bus.o_TRAP}, 32'd0);
        chk("rst_in_trap", {31'd0, bus.o_IN_TRAP}, 32'd0);
        chk("rst_mepc", bus.o_MEPC, 32'd0);
        finish_cycle();
`ifdef CSR_TIMER_EN
        set_in(0, 3'd0, 12'h7C1, 32'd0, 0, 0, 32'h0, '0);
        settle();
        chk("rst_mtimecmph", bus.o_CSR_RDATA, 32'hFFFF_FFFF);
        finish_cycle();
`endif
        do_reset('0);

        for (int k = 0; k < NV; k++) begin
            set_in(vecs[k].en, vecs[k].f3, vecs[k].addr, vecs[k].wd,
                   vecs[k].ret, vecs[k].mret, vecs[k].pc, vecs[k].irq);
            settle();
            chk($sformatf("vec%0d_rdata", k), bus.o_CSR_RDATA, vecs[k].exp_rd);
            chk($sformatf("vec%0d_trap", k), {31'd0, bus.o_TRAP}, {31'd0, vecs[k].exp_trap});
            if (vecs[k].exp_trap) chk($sformatf("vec%0d_tpc", k), bus.o_TRAP_PC, vecs[k].exp_tpc);
            chk($sformatf("vec%0d_in_trap", k), {31'd0, bus.o_IN_TRAP}, {31'd0, vecs[k].exp_it});
            finish_cycle();
        end

        // Masking: MIE=0 with a pending enabled line never traps.
        do_reset('0);
        set_in(1, 3'd1, 12'h304, 32'h0001_0000, 0, 0, 32'h0, 6'b000000); tick();
        set_in(0, 3'd0, 12'h000, 32'd0,         0, 0, 32'h0, 6'b000001); tick();
        for (int k = 0; k < 10; k++) begin
            set_in(0, 3'd0, 12'h000, 32'd0, 1, 0, 32'(16 + 4 * k), 6'b000001);
            settle();
            chk("masked_no_trap", {31'd0, bus.o_TRAP}, 32'd0);
            finish_cycle();
        end
        set_in(1, 3'd1, 12'h300, 32'h8, 0, 0, 32'h0, 6'b000001); tick();
        set_in(0, 3'd0, 12'h000, 32'd0, 1, 0, 32'h60, 6'b000001);
        settle(); chk("unmasked_trap", {31'd0, bus.o_TRAP}, 32'd1); finish_cycle();
        set_in(0, 3'd0, 12'h000, 32'd0, 1, 1, 32'h70, 6'b000001);
        settle();
        chk("mret_in_handler", {31'd0, bus.o_IN_TRAP}, 32'd1);
        chk("mret_no_trap", {31'd0, bus.o_TRAP}, 32'd0);
        finish_cycle();
        set_in(0, 3'd0, 12'h300, 32'd0, 1, 0, 32'h64, 6'b000001);
        settle();
        chk("after_mret_mstatus", bus.o_CSR_RDATA, 32'h88);
        chk("after_mret_in_trap", {31'd0, bus.o_IN_TRAP}, 32'd0);
        chk("retrap_pending", {31'd0, bus.o_TRAP}, 32'd1);
        finish_cycle();

        // Set/clear collision on mip[16].
        set_in(1, 3'd3, 12'h344, 32'h0001_0000, 0, 0, 32'h0, 6'b000000); tick();
        set_in(0, 3'd0, 12'h344, 32'd0, 0, 0, 32'h0, 6'b000000);
        settle(); chk("mip_cleared", bus.o_CSR_RDATA, 32'd0); finish_cycle();
        set_in(1, 3'd3, 12'h344, 32'h0001_0000, 0, 0, 32'h0, 6'b000001); tick();
        set_in(0, 3'd0, 12'h344, 32'd0, 0, 0, 32'h0, 6'b000001);
        settle(); chk("collision_set_wins", bus.o_CSR_RDATA, 32'h0001_0000); finish_cycle();
        set_in(1, 3'd3, 12'h344, 32'h0001_0000, 0, 0, 32'h0, 6'b000001); tick();
        set_in(0, 3'd0, 12'h344, 32'd0, 0, 0, 32'h0, 6'b000001);
        settle(); chk("level_no_relatch", bus.o_CSR_RDATA, 32'd0); finish_cycle();
        set_in(1, 3'd1, 12'h344, 32'hFFFF_FFFF, 0, 0, 32'h0, 6'b000001); tick();
        set_in(0, 3'd0, 12'h344, 32'd0, 0, 0, 32'h0, 6'b000001);
        settle(); chk("mip_write_ignored", bus.o_CSR_RDATA, 32'd0); finish_cycle();

        // mie mask, read-only mcycle, mepc/mtvec forced bits.
        set_in(1, 3'd1, 12'h304, 32'hFFFF_FFFF, 0, 0, 32'h0, '0); tick();
        set_in(0, 3'd0, 12'h304, 32'd0, 0, 0, 32'h0, '0);
        settle(); chk("mie_mask", bus.o_CSR_RDATA, mie_mask()); finish_cycle();
        set_in(1, 3'd1, 12'hB00, 32'd0, 0, 0, 32'h0, '0); tick();
        set_in(1, 3'd1, 12'hB80, 32'hFFFF_FFFF, 0, 0, 32'h0, '0); tick();
        set_in(0, 3'd0, 12'hB80, 32'd0, 0, 0, 32'h0, '0);
        settle(); chk("mcycleh_ro", bus.o_CSR_RDATA, 32'd0); finish_cycle();
        set_in(1, 3'd1, 12'h341, 32'h1234_5677, 0, 0, 32'h0, '0); tick();
        set_in(1, 3'd1, 12'h305, 32'hFFFF_FFFF, 0, 0, 32'h0, '0);
        settle(); chk("mepc_align", bus.o_MEPC, 32'h1234_5674); finish_cycle();
        set_in(0, 3'd0, 12'h305, 32'd0, 0, 0, 32'h0, '0);
        settle(); chk("mtvec_bit1", bus.o_CSR_RDATA, 32'hFFFF_FFFD); finish_cycle();

        // Reset mid-handler with a line held high through reset.
        set_in(1, 3'd1, 12'h305, 32'h0000_0400, 0, 0, 32'h0, '0); tick();
        set_in(1, 3'd1, 12'h300, 32'h8, 0, 0, 32'h0, 6'b000100); tick();
        set_in(0, 3'd0, 12'h000, 32'd0, 1, 0, 32'h90, 6'b000100);
        settle(); chk("pre_reset_trap", {31'd0, bus.o_TRAP}, 32'd1); finish_cycle();
        do_reset(6'b000100);
        set_in(0, 3'd0, 12'h344, 32'd0, 0, 0, 32'h0, 6'b000100);
        settle();
        chk("reset_mid_in_trap", {31'd0, bus.o_IN_TRAP}, 32'd0);
        chk("reset_mid_mepc", bus.o_MEPC, 32'd0);
        chk("reset_mid_mip", bus.o_CSR_RDATA, 32'd0);
        finish_cycle();
        set_in(0, 3'd0, 12'h344, 32'd0, 0, 0, 32'h0, 6'b000100);
        settle(); chk("held_line_latches", bus.o_CSR_RDATA, 32'h0004_0000); finish_cycle();

        // Randomized traffic against the model.
        irq_r = '0;
        for (int c = 0; c < 600; c++) begin
            logic [11:0] alist[14];
            logic [11:0] a;
            alist = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                      12'h344, 12'h344, 12'hB00, 12'hB80, 12'h7C0, 12'h7C1, 12'h123};
            a = alist[$urandom_range(0, 13)];
            for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) irq_r[i] = ~irq_r[i];
            set_in($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, $urandom,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, $urandom, irq_r);
            tick();
        end

`ifdef CSR_TIMER_EN
        do_reset('0);
        set_in(1, 3'd1, 12'h7C0, 32'd50, 0, 0, 32'h0, '0); tick();
        set_in(1, 3'd1, 12'h7C1, 32'd0,  0, 0, 32'h0, '0); tick();
        set_in(1, 3'd1, 12'h304, 32'h80, 0, 0, 32'h0, '0); tick();
        set_in(1, 3'd1, 12'h300, 32'h8,  0, 0, 32'h0, '0); tick();
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            set_in(0, 3'd0, 12'hB00, 32'd0, 1, 0, 32'h200, '0);
            settle();
            if (bus.o_TRAP) begin
                found = 1;
                chk("timer_trap_cycle", bus.o_CSR_RDATA, 32'd50);
            end
            finish_cycle();
        end
        if (!found) chk("timer_wait_timeout", 32'd0, 32'd1);
        set_in(0, 3'd0, 12'h342, 32'd0, 0, 0, 32'h0, '0);
        settle(); chk("timer_mcause", bus.o_CSR_RDATA, 32'h8000_0007); finish_cycle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
